// File: rtl/cps2_sync_lock_ctrl_pkg.sv
// rtl/cps2_sync_lock_ctrl_pkg.sv - CPS2 timing constants and lock state encodings
package cps2_sync_lock_ctrl_pkg;

  localparam int H_TOTAL      = 512;
  localparam int V_TOTAL      = 262;
  localparam int PCLK_PER_PIX = 2;
  localparam int H_PERIOD_NOM = H_TOTAL * PCLK_PER_PIX;

  localparam int H_SAT = 2047;
  localparam int V_SAT = 1023;

  typedef enum logic [1:0] {
    ST_NOSIG   = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_HOLD    = 2'd3
  } lock_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/cps2_sync_lock_ctrl_sync_period_meter.sv
// rtl/cps2_sync_lock_ctrl_sync_period_meter.sv - sync edge detect, line/frame measurement
module cps2_sync_lock_ctrl_sync_period_meter
  import cps2_sync_lock_ctrl_pkg::*;
#(
  parameter int H_PERIOD_EXP = H_PERIOD_NOM,
  parameter int H_TOL        = 4,
  parameter int V_TOTAL_EXP  = V_TOTAL
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hsync,
  input  logic        vsync,
  output logic [10:0] h_period,
  output logic [9:0]  v_lines,
  output logic        frame_bnd,
  output logic        frame_ok,
  output logic        timeout
);

  logic        hs_d1, hs_d2, vs_d1, vs_prev;
  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic        frame_bad;
  logic        h_edge, v_fall, line_bad;
  logic [11:0] h_next;
  logic [10:0] h_meas;
  logic [10:0] v_next;
  logic [9:0]  v_meas;

  assign h_edge    = hs_d2 & ~hs_d1;
  assign v_fall    = vs_prev & ~vs_d1;
  assign frame_bnd = h_edge & v_fall;
  // An edge in the same cycle as saturation means the line did arrive in time.
  assign timeout   = (h_cnt == 11'(H_SAT)) & ~h_edge;

  // Saturating "+1" views of the counters and the tolerance window test.
  always_comb begin
    h_next   = {1'b0, h_cnt} + 12'd1;
    h_meas   = h_next[11] ? 11'(H_SAT) : h_next[10:0];
    v_next   = {1'b0, v_cnt} + 11'd1;
    v_meas   = v_next[10] ? 10'(V_SAT) : v_next[9:0];
    line_bad = (int'(h_next) > H_PERIOD_EXP + H_TOL) ||
               (int'(h_next) < H_PERIOD_EXP - H_TOL);
    frame_ok = (int'(v_next) == V_TOTAL_EXP) & ~frame_bad & ~line_bad;
  end

  // Sync input registers; VSYNC history only advances on HSYNC falling edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_d1   <= 1'b1;
      hs_d2   <= 1'b1;
      vs_d1   <= 1'b1;
      vs_prev <= 1'b1;
    end else begin
      hs_d1 <= hsync;
      hs_d2 <= hs_d1;
      vs_d1 <= vsync;
      if (h_edge) vs_prev <= vs_d1;
    end
  end

  // Line/frame counters, captured measurements and the sticky bad-line flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      h_period  <= '0;
      v_lines   <= '0;
      frame_bad <= 1'b0;
    end else if (h_edge) begin
      h_cnt    <= '0;
      h_period <= h_meas;
      if (frame_bnd) begin
        v_cnt     <= '0;
        v_lines   <= v_meas;
        frame_bad <= 1'b0;
      end else begin
        v_cnt <= v_meas;
        if (line_bad) frame_bad <= 1'b1;
      end
    end else begin
      if (h_cnt != 11'(H_SAT)) h_cnt <= h_cnt + 11'd1;
      if (timeout) v_cnt <= '0;
    end
  end

endmodule

// File: rtl/cps2_sync_lock_ctrl.sv
// rtl/cps2_sync_lock_ctrl.sv - CPS2 video timing lock supervisor with hysteresis
module cps2_sync_lock_ctrl
  import cps2_sync_lock_ctrl_pkg::*;
#(
  parameter int H_PERIOD_EXP  = H_PERIOD_NOM,
  parameter int H_TOL         = 4,
  parameter int V_TOTAL_EXP   = V_TOTAL,
  parameter int LOCK_FRAMES   = 4,
  parameter int UNLOCK_FRAMES = 2
) (
  input  logic        PCLK_i,
  input  logic        reset_n,
  input  logic        HSYNC_i,
  input  logic        VSYNC_i,
  output logic [10:0] h_period,
  output logic [9:0]  v_lines,
  output logic        frame_start,
  output logic [1:0]  state_o,
  output logic        locked,
  output logic        mute_o,
  output logic [7:0]  err_cnt
);

  localparam logic [3:0] LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0] UNLOCK_N = 4'(UNLOCK_FRAMES);

  lock_state_t state, state_nxt;
  logic [3:0]  good_cnt, good_nxt, bad_cnt, bad_nxt;
  logic [7:0]  err_nxt;
  logic        frame_bnd, frame_ok, timeout;

  cps2_sync_lock_ctrl_sync_period_meter #(
    .H_PERIOD_EXP(H_PERIOD_EXP),
    .H_TOL       (H_TOL),
    .V_TOTAL_EXP (V_TOTAL_EXP)
  ) u_meter (
    .clk      (PCLK_i),
    .rst_n    (reset_n),
    .hsync    (HSYNC_i),
    .vsync    (VSYNC_i),
    .h_period (h_period),
    .v_lines  (v_lines),
    .frame_bnd(frame_bnd),
    .frame_ok (frame_ok),
    .timeout  (timeout)
  );

  assign state_o = state;
  assign locked  = (state == ST_LOCKED) || (state == ST_HOLD);

  // Lock FSM: timeout overrides everything, otherwise scored at frame boundaries.
  always_comb begin
    state_nxt = state;
    good_nxt  = good_cnt;
    bad_nxt   = bad_cnt;
    err_nxt   = err_cnt;
    if (timeout) begin
      state_nxt = ST_NOSIG;
      good_nxt  = '0;
      bad_nxt   = '0;
    end else if (frame_bnd) begin
      case (state)
        ST_NOSIG: begin
          // First frame after signal appears is partial, so it is not scored.
          state_nxt = ST_ACQUIRE;
          good_nxt  = '0;
          bad_nxt   = '0;
        end
        ST_ACQUIRE: begin
          if (!frame_ok) begin
            good_nxt = '0;
          end else if (good_cnt + 4'd1 == LOCK_N) begin
            state_nxt = ST_LOCKED;
            good_nxt  = '0;
            bad_nxt   = '0;
          end else begin
            good_nxt = good_cnt + 4'd1;
          end
        end
        ST_LOCKED: begin
          if (!frame_ok) begin
            err_nxt = sat_inc8(err_cnt);
            bad_nxt = 4'd1;
            if (UNLOCK_N == 4'd1) begin
              state_nxt = ST_ACQUIRE;
              good_nxt  = '0;
              bad_nxt   = '0;
            end else begin
              state_nxt = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (frame_ok) begin
            state_nxt = ST_LOCKED;
            bad_nxt   = '0;
          end else begin
            err_nxt = sat_inc8(err_cnt);
            if (bad_cnt + 4'd1 == UNLOCK_N) begin
              state_nxt = ST_ACQUIRE;
              good_nxt  = '0;
              bad_nxt   = '0;
            end else begin
              bad_nxt = bad_cnt + 4'd1;
            end
          end
        end
        default: state_nxt = ST_NOSIG;
      endcase
    end
  end

  // State, hysteresis counters, error count, boundary pulse and muting register.
  always_ff @(posedge PCLK_i or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_NOSIG;
      good_cnt    <= '0;
      bad_cnt     <= '0;
      err_cnt     <= '0;
      frame_start <= 1'b0;
      mute_o      <= 1'b1;
    end else begin
      state       <= state_nxt;
      good_cnt    <= good_nxt;
      bad_cnt     <= bad_nxt;
      err_cnt     <= err_nxt;
      frame_start <= frame_bnd;
      mute_o      <= ~locked;
    end
  end

endmodule

// File: tb/tb_cps2_sync_lock_ctrl.sv
// tb/tb_cps2_sync_lock_ctrl.sv - self-checking bench for cps2_sync_lock_ctrl
module tb_cps2_sync_lock_ctrl;

  logic        clk     = 1'b0;
  logic        reset_n = 1'b0;
  logic        hs      = 1'b1;
  logic        vs      = 1'b1;
  logic [10:0] h_period;
  logic [9:0]  v_lines;
  logic        frame_start;
  logic [1:0]  state_o;
  logic        locked;
  logic        mute_o;
  logic [7:0]  err_cnt;

  always #5 clk = ~clk;

  cps2_sync_lock_ctrl #(
    .H_PERIOD_EXP (64),
    .H_TOL        (4),
    .V_TOTAL_EXP  (12),
    .LOCK_FRAMES  (4),
    .UNLOCK_FRAMES(2)
  ) dut (
    .PCLK_i     (clk),
    .reset_n    (reset_n),
    .HSYNC_i    (hs),
    .VSYNC_i    (vs),
    .h_period   (h_period),
    .v_lines    (v_lines),
    .frame_start(frame_start),
    .state_o    (state_o),
    .locked     (locked),
    .mute_o     (mute_o),
    .err_cnt    (err_cnt)
  );

  typedef struct {
    int gap;
    int lines;
    int period;
    int exp_state;
    int exp_err;
    int exp_vl;
    int exp_hp;
  } vec_t;

  typedef struct {
    int state;
    int err;
    int vl;
    int hp;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_line(input int period, input logic v);
    @(negedge clk);
    hs = 1'b0;
    vs = v;
    repeat (8) @(negedge clk);
    hs = 1'b1;
    repeat (period - 9) @(negedge clk);
  endtask

  task automatic drive_frame(input int lines, input int period, input exp_t e);
    sb.push_back(e);
    for (int l = 0; l < lines; l++) drive_line(period, (l < 3) ? 1'b0 : 1'b1);
  endtask

  // Scoreboard consumer: one expectation per frame_start pulse.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && frame_start) begin
        if (sb.size() == 0) begin
          check("frame_start_unexpected", sb.size(), 1);
        end else begin
          mon_e = sb.pop_front();
          check("state_o", int'(state_o), mon_e.state);
          check("locked", int'(locked), (mon_e.state >= 2) ? 1 : 0);
          check("err_cnt", int'(err_cnt), mon_e.err);
          check("v_lines", int'(v_lines), mon_e.vl);
          if (mon_e.hp != 0) check("h_period", int'(h_period), mon_e.hp);
          @(negedge clk);
          check("mute_o_lag", int'(mute_o), (mon_e.state >= 2) ? 0 : 1);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[22];
    exp_t e;
    tbl[0]  = '{0,    12, 64, 1, 0, 1,  0};
    tbl[1]  = '{0,    12, 68, 1, 0, 12, 64};
    tbl[2]  = '{0,    12, 69, 1, 0, 12, 68};
    tbl[3]  = '{0,    12, 64, 1, 0, 12, 69};
    tbl[4]  = '{0,    12, 64, 1, 0, 12, 64};
    tbl[5]  = '{0,    12, 64, 1, 0, 12, 64};
    tbl[6]  = '{0,    12, 64, 1, 0, 12, 64};
    tbl[7]  = '{0,    12, 64, 2, 0, 12, 64};
    tbl[8]  = '{0,    13, 64, 2, 0, 12, 64};
    tbl[9]  = '{0,    12, 64, 3, 1, 13, 64};
    tbl[10] = '{0,    10, 64, 2, 1, 12, 64};
    tbl[11] = '{0,    10, 64, 3, 2, 10, 64};
    tbl[12] = '{0,    12, 64, 1, 3, 10, 64};
    tbl[13] = '{0,    12, 64, 1, 3, 12, 64};
    tbl[14] = '{0,    12, 64, 1, 3, 12, 64};
    tbl[15] = '{0,    12, 64, 1, 3, 12, 64};
    tbl[16] = '{0,    12, 64, 2, 3, 12, 64};
    tbl[17] = '{3000, 12, 64, 1, 3, 1,  2047};
    tbl[18] = '{0,    12, 64, 1, 3, 12, 64};
    tbl[19] = '{0,    12, 64, 1, 3, 12, 64};
    tbl[20] = '{0,    12, 64, 1, 3, 12, 64};
    tbl[21] = '{0,    12, 64, 2, 3, 12, 64};

    @(negedge clk);
    check("rst_state_o", int'(state_o), 0);
    check("rst_locked", int'(locked), 0);
    check("rst_mute_o", int'(mute_o), 1);
    check("rst_err_cnt", int'(err_cnt), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_h_period", int'(h_period), 0);
    check("rst_v_lines", int'(v_lines), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      if (tbl[i].gap > 0) begin
        repeat (tbl[i].gap) @(negedge clk);
        check("timeout_state_o", int'(state_o), 0);
        check("timeout_locked", int'(locked), 0);
        check("timeout_mute_o", int'(mute_o), 1);
      end
      e = '{tbl[i].exp_state, tbl[i].exp_err, tbl[i].exp_vl, tbl[i].exp_hp};
      drive_frame(tbl[i].lines, tbl[i].period, e);
    end

    e = '{2, 3, 12, 64};
    sb.push_back(e);
    for (int l = 0; l < 5; l++) drive_line(64, (l < 3) ? 1'b0 : 1'b1);
    check("pre_reset_state_o", int'(state_o), 2);
    check("pre_reset_err_cnt", int'(err_cnt), 3);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_state_o", int'(state_o), 0);
    check("midrst_locked", int'(locked), 0);
    check("midrst_mute_o", int'(mute_o), 1);
    check("midrst_err_cnt", int'(err_cnt), 0);
    check("midrst_frame_start", int'(frame_start), 0);
    check("midrst_h_period", int'(h_period), 0);
    check("midrst_v_lines", int'(v_lines), 0);
    check("scoreboard_drained", sb.size(), 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cps2_sync_lock_ctrl.md
Name: cps2_sync_lock_ctrl

Overview:
Supervises the CPS2 video input timing ahead of the frontend/scaler path. Measures line period (PCLK cycles) and lines per frame from raw HSYNC_i/VSYNC_i. Runs a lock state machine with hysteresis and drives locked/mute controls that gate the frontend output and the downstream mclk/scaler configuration. Runs in the PCLK_i domain, in parallel with the frontend.

Parameters:
H_PERIOD_EXP, 1024, expected PCLK cycles per line (512 pixels x 2-cycle pixel divider)
H_TOL, 4, allowed |measured - expected| line period, in cycles
V_TOTAL_EXP, 262, expected lines per frame
LOCK_FRAMES, 4, consecutive good frames required to lock (1..15)
UNLOCK_FRAMES, 2, consecutive bad frames required to drop lock (1..15)

Ports:
PCLK_i  in  1  pixel clock, frontend clock
reset_n  in  1  asynchronous active-low reset
HSYNC_i  in  1  raw hsync, active low
VSYNC_i  in  1  raw vsync, active low, sampled at HSYNC falling edges
h_period  out  11  last measured line period, saturating at 2047
v_lines  out  10  last measured lines per frame, saturating at 1023
frame_start  out  1  one-cycle pulse at each detected frame boundary
state_o  out  2  0=NOSIG 1=ACQUIRE 2=LOCKED 3=HOLD
locked  out  1  state is LOCKED or HOLD
mute_o  out  1  registered ~locked; forces blanking downstream
err_cnt  out  8  saturating count of bad frames seen while locked

Behaviour:
- Reset (async, reset_n=0): all counters and registers 0; state NOSIG; locked=0; mute_o=1; frame_start=0. Internal sync history registers reset to 1 (idle high).
- Edge detect: HSYNC falling edge = prev & ~cur on registered HSYNC_i. Frame boundary = HSYNC falling edge while VSYNC history shows a falling edge. VSYNC history updates only at HSYNC edges, as in the frontend.
- h_cnt: 11 bits, saturates at 2047.
  - On an H edge: h_period <= h_cnt+1 (saturating); h_cnt <= 0.
  - line_bad = |h_cnt+1 - H_PERIOD_EXP| > H_TOL. It sets the sticky frame_bad flag.
- v_cnt: 10 bits, +1 per H edge, saturating.
  - On a frame boundary: v_lines <= v_cnt+1; v_cnt <= 0.
  - frame_ok = (v_cnt+1 == V_TOTAL_EXP) & ~frame_bad & ~line_bad(current edge).
  - frame_bad clears at the frame boundary.
- Timeout: h_cnt reaching 2047 means no H edge in 2047 cycles. In any state: next state NOSIG, good/bad counters cleared, v_cnt cleared. h_period reads 2047.
- Same-cycle edge and timeout: the edge wins, and no timeout is taken.
- Lock FSM. Evaluated only on frame boundaries, except for timeout:
  - NOSIG: first frame boundary -> ACQUIRE, good_cnt=0. That frame is not scored, because the first frame is partial.
  - ACQUIRE:
    - frame_ok: good_cnt+1; when good_cnt+1 == LOCK_FRAMES -> LOCKED.
    - Otherwise: good_cnt=0, stay in ACQUIRE.
  - LOCKED:
    - bad frame: err_cnt+1 (saturating at 255), bad_cnt=1; -> HOLD, or -> ACQUIRE if UNLOCK_FRAMES==1.
    - frame_ok: stay in LOCKED.
  - HOLD:
    - frame_ok: -> LOCKED, bad_cnt=0.
    - bad frame: err_cnt+1, bad_cnt+1; when bad_cnt+1 == UNLOCK_FRAMES -> ACQUIRE with good_cnt=0.
- Latency:
  - state_o and locked change on the cycle after the boundary or timeout edge is detected.
  - mute_o follows locked one cycle later.
  - frame_start is coincident with the state_o update.
- err_cnt clears only on reset.
- Reset mid-frame: immediate return to reset values; resumes in NOSIG.

Decomposition:
- Shared package/header (cps2_timing.vh, next to mclk_cfg_ids.vh):
  - CPS2 timing constants: H_TOTAL 512, V_TOTAL 262, PCLK-per-pixel 2.
  - State encodings NOSIG/ACQUIRE/LOCKED/HOLD.
- One natural sub-module, sync_period_meter: edge detect, saturating h_cnt/v_cnt, and h_period/v_lines/line_bad/frame boundary generation.
- The FSM, hysteresis counters and err_cnt stay in the top module.

Test Plan:
- Nominal CPS2 timing (1024-cycle lines, 262 lines, VSYNC 3 lines) -> h_period=1024, v_lines=262; state NOSIG->ACQUIRE at the 1st boundary, LOCKED after 4 scored frames; mute_o=0 one cycle after locked=1.
- Line period 1028, then 1029, while acquiring -> 1028 is accepted. 1029 resets good_cnt to 0; lock requires 4 further good frames.
- Locked, then one frame of 263 lines -> HOLD, err_cnt=1, locked stays 1. Next good frame -> LOCKED.
- Locked, then two consecutive 250-line frames -> HOLD then ACQUIRE; locked=0, mute_o=1, err_cnt=2.
- HSYNC held high for 3000 cycles while locked -> state NOSIG once h_cnt hits 2047; h_period=2047 at the next edge. Lock needs 1 unscored + 4 good frames.
- reset_n asserted mid-frame while LOCKED -> all outputs take reset values immediately (mute_o=1, err_cnt=0, state_o=0), with no clock edge required.
